mc_control_unit: RTL
====================

MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 The block SHALL expose these ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- op  in  7  instruction opcode [6:0]
- funct3  in  3  instruction funct3
- funct7b5  in  1  instruction bit 30
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory handshake, access completes in the cycle it is high
- pcwrite  out  1  PC register enable
- adrsrc  out  1  memory address select: 0=PC, 1=ALU result
- memwrite  out  1  data memory write strobe
- irwrite  out  1  instruction register enable
- resultsrc  out  2  00=ALUOut, 01=ReadData, 10=ALU result
- alusrca  out  2  00=PC, 01=OldPC, 10=rs1
- alusrcb  out  2  00=rs2, 01=immext, 10=constant 4
- immsrc  out  3  immediate format to the immediate extender: I=000, S=001, U=010, B=101, J=110
- alucontrol  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- regwrite  out  1  register file write enable
- illegal  out  1  sticky illegal-opcode flag
- state  out  4  current FSM state, for debug

Function
REQ-002 The FSM SHALL use these states and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, UTYPE=11, TRAP=15.
REQ-003 FETCH SHALL drive adrsrc=0, alusrca=00, alusrcb=10, add, resultsrc=10. It SHALL hold until mem_ready=1. In that cycle it SHALL assert irwrite and pcwrite and go to DECODE.
REQ-004 DECODE SHALL drive alusrca=01, alusrcb=01, add, with immsrc=B, to precompute the branch target.
REQ-005 DECODE SHALL dispatch on op:
- 0000011 or 0100011 -> MEMADR
- 0110011 -> EXECR
- 0010011 -> EXECI
- 1100011 -> BRANCH
- 1101111 -> JAL
- 0110111 or 0010111 -> UTYPE
- any other value -> TRAP, and set illegal
REQ-006 MEMADR SHALL drive alusrca=10, alusrcb=01, add. immsrc SHALL be S for stores and I for loads. It SHALL go to MEMREAD for loads and MEMWRITE for stores.
REQ-007 MEMREAD and MEMWRITE SHALL drive adrsrc=1 and hold until mem_ready=1. memwrite SHALL be asserted only in the MEMWRITE cycle where mem_ready=1, so exactly one pulse per store. MEMREAD SHALL then go to MEMWB. MEMWRITE SHALL then go to FETCH.
REQ-008 MEMWB SHALL drive resultsrc=01 and regwrite=1, then go to FETCH.
REQ-009 EXECR and EXECI SHALL drive alusrca=10. alusrcb SHALL be 00 in EXECR and 01 in EXECI, with immsrc=I. The next state SHALL be ALUWB.
REQ-010 ALU decode SHALL map funct3 as: 000 -> add, or sub only when op[5]=1 and funct7b5=1; 010 -> slt; 110 -> or; 111 -> and; any other value -> add.
REQ-011 ALUWB SHALL drive resultsrc=00 and regwrite=1, then go to FETCH.
REQ-012 BRANCH SHALL drive alusrca=10, alusrcb=00, sub, resultsrc=00. It SHALL assert pcwrite when zero XOR funct3[0] is 1 (beq/bne), then go to FETCH.
REQ-013 JAL SHALL drive alusrca=01, alusrcb=10, add, resultsrc=00, immsrc=J, pcwrite=1, then go to ALUWB.
REQ-014 In every state, any output not listed SHALL be 0, except immsrc, which SHALL be 000.
REQ-015 TRAP SHALL be absorbing, with all enables at 0. It SHALL be left only by reset.
REQ-016 Every instruction SHALL start with FETCH, and the FSM SHALL never skip FETCH.
REQ-017 Minimum latency with mem_ready tied high SHALL be: R/I 4 cycles, load 5, store 4, branch 3, jal 4, U-type 4.

Reset
REQ-018 While rst_n=0, the block SHALL set state=FETCH and illegal=0 asynchronously. All enables SHALL be 0, with no reset-time memory pulse.
REQ-019 Reset deasserted mid-instruction SHALL abandon the instruction without a partial write. The block SHALL resume in FETCH on the first rising clk after rst_n=1.

Configuration
REQ-020 Macro UTYPE_SUPPORT_EN SHALL control U-type support.
- Defined: UTYPE SHALL drive alusrcb=01 and immsrc=U. alusrca SHALL be 01 for auipc (op[5]=0). For lui, A SHALL be forced to zero through alusrca=11. The next state SHALL be ALUWB.
- Undefined: the UTYPE state SHALL be absent, and opcodes 0110111/0010111 SHALL go to TRAP.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset with mem_ready=1, op=0110011, funct3=000, funct7b5=1 -> states 0,1,6,8,0; alucontrol=001 in EXECR; regwrite=1 only in ALUWB.
- Load op=0000011 with mem_ready low for 3 MEMREAD cycles -> state holds at 3, adrsrc=1, no regwrite; MEMWB follows the ready cycle.
- Store op=0100011 -> immsrc=001 in MEMADR; exactly one memwrite pulse.
- Branch op=1100011, funct3=001, zero=0 -> pcwrite=1 in BRANCH. With zero=1 -> pcwrite=0.
- op=1111111 -> TRAP, illegal=1, stays until rst_n pulses low; then state=0, illegal=0.
- lui op=0110111 -> with macro defined: immsrc=010, ALUWB writes. With macro undefined: TRAP.

Source files
------------

// File: rtl/mc_control_unit.sv
// -----------------------------------------------------------------------------
// mc_control_unit
// Multicycle RISC-V style control FSM. It sequences fetch, decode, address
// generation, memory access, execute and writeback, and drives the datapath
// mux selects and write enables for each phase.
//
// Ports
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   op, funct3,    instruction fields (op[6:0], funct3, bit 30)
//   funct7b5
//   zero           ALU zero flag, used for beq/bne
//   mem_ready      memory handshake; an access completes in the cycle it is high
//   pcwrite        PC register enable
//   adrsrc         memory address select (0 = PC, 1 = ALU result)
//   memwrite       data memory write strobe, one pulse per store
//   irwrite        instruction register enable
//   resultsrc      result mux (00 ALUOut, 01 ReadData, 10 ALU result)
//   alusrca        ALU A select (00 PC, 01 OldPC, 10 rs1, 11 zero)
//   alusrcb        ALU B select (00 rs2, 01 immext, 10 constant 4)
//   immsrc         immediate format (I 000, S 001, U 010, B 101, J 110)
//   alucontrol     ALU operation (000 add, 001 sub, 010 and, 011 or, 101 slt)
//   regwrite       register file write enable
//   illegal        sticky illegal-opcode flag
//   state          current FSM state, for debug
//
// Configuration
//   UTYPE_SUPPORT_EN  when defined, lui/auipc execute through the UTYPE state;
//                     when undefined, those opcodes are treated as illegal.
// -----------------------------------------------------------------------------
module mc_control_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       adrsrc,
    output logic       memwrite,
    output logic       irwrite,
    output logic [1:0] resultsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] immsrc,
    output logic [2:0] alucontrol,
    output logic       regwrite,
    output logic       illegal,
    output logic [3:0] state
);

    localparam int unsigned STATE_W = 4;

    // FSM state encodings
    localparam logic [STATE_W-1:0] S_FETCH    = 4'd0;
    localparam logic [STATE_W-1:0] S_DECODE   = 4'd1;
    localparam logic [STATE_W-1:0] S_MEMADR   = 4'd2;
    localparam logic [STATE_W-1:0] S_MEMREAD  = 4'd3;
    localparam logic [STATE_W-1:0] S_MEMWB    = 4'd4;
    localparam logic [STATE_W-1:0] S_MEMWRITE = 4'd5;
    localparam logic [STATE_W-1:0] S_EXECR    = 4'd6;
    localparam logic [STATE_W-1:0] S_EXECI    = 4'd7;
    localparam logic [STATE_W-1:0] S_ALUWB    = 4'd8;
    localparam logic [STATE_W-1:0] S_BRANCH   = 4'd9;
    localparam logic [STATE_W-1:0] S_JAL      = 4'd10;
`ifdef UTYPE_SUPPORT_EN
    localparam logic [STATE_W-1:0] S_UTYPE    = 4'd11;
`endif
    localparam logic [STATE_W-1:0] S_TRAP     = 4'd15;

    // Opcodes
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
`ifdef UTYPE_SUPPORT_EN
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
`endif

    // ALU operations
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Immediate formats
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
`ifdef UTYPE_SUPPORT_EN
    localparam logic [2:0] IMM_U = 3'b010;
`endif
    localparam logic [2:0] IMM_B = 3'b101;
    localparam logic [2:0] IMM_J = 3'b110;

    // Mux select codes
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
`ifdef UTYPE_SUPPORT_EN
    localparam logic [1:0] SRCA_ZERO  = 2'b11;
`endif
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic               illegal_q;
    logic               illegal_set_c;
    logic [2:0]         alu_dec_c;

    // Unqualified enables; gated by reset below so nothing fires while held
    logic pcwrite_c;
    logic irwrite_c;
    logic memwrite_c;
    logic regwrite_c;

    // funct3 decode for register and immediate ALU instructions
    always_comb begin
        alu_dec_c = ALU_ADD;
        case (funct3)
            3'b000:  alu_dec_c = (op[5] && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_dec_c = ALU_SLT;
            3'b110:  alu_dec_c = ALU_OR;
            3'b111:  alu_dec_c = ALU_AND;
            default: alu_dec_c = ALU_ADD;
        endcase
    end

    // State and sticky illegal flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_q | illegal_set_c;
        end
    end

    // Next-state and per-state datapath controls
    always_comb begin
        state_d       = state_q;
        illegal_set_c = 1'b0;
        pcwrite_c     = 1'b0;
        irwrite_c     = 1'b0;
        memwrite_c    = 1'b0;
        regwrite_c    = 1'b0;
        adrsrc        = 1'b0;
        resultsrc     = 2'b00;
        alusrca       = 2'b00;
        alusrcb       = 2'b00;
        immsrc        = 3'b000;
        alucontrol    = ALU_ADD;

        case (state_q)
            S_FETCH: begin
                adrsrc     = 1'b0;
                alusrca    = SRCA_PC;
                alusrcb    = SRCB_FOUR;
                alucontrol = ALU_ADD;
                resultsrc  = RES_ALU;
                if (mem_ready) begin
                    irwrite_c = 1'b1;
                    pcwrite_c = 1'b1;
                    state_d   = S_DECODE;
                end
            end

            // Branch target is precomputed here into ALUOut
            S_DECODE: begin
                alusrca    = SRCA_OLDPC;
                alusrcb    = SRCB_IMM;
                alucontrol = ALU_ADD;
                immsrc     = IMM_B;
                case (op)
                    OP_LOAD,
                    OP_STORE:  state_d = S_MEMADR;
                    OP_RTYPE:  state_d = S_EXECR;
                    OP_ITYPE:  state_d = S_EXECI;
                    OP_BRANCH: state_d = S_BRANCH;
                    OP_JAL:    state_d = S_JAL;
`ifdef UTYPE_SUPPORT_EN
                    OP_LUI,
                    OP_AUIPC:  state_d = S_UTYPE;
`endif
                    default: begin
                        state_d       = S_TRAP;
                        illegal_set_c = 1'b1;
                    end
                endcase
            end

            // op[5] separates stores from loads
            S_MEMADR: begin
                alusrca    = SRCA_RS1;
                alusrcb    = SRCB_IMM;
                alucontrol = ALU_ADD;
                immsrc     = op[5] ? IMM_S : IMM_I;
                state_d    = op[5] ? S_MEMWRITE : S_MEMREAD;
            end

            S_MEMREAD: begin
                adrsrc = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end
            end

            S_MEMWB: begin
                resultsrc  = RES_RDATA;
                regwrite_c = 1'b1;
                state_d    = S_FETCH;
            end

            // Strobe only on the completing cycle, so one pulse per store
            S_MEMWRITE: begin
                adrsrc = 1'b1;
                if (mem_ready) begin
                    memwrite_c = 1'b1;
                    state_d    = S_FETCH;
                end
            end

            S_EXECR: begin
                alusrca    = SRCA_RS1;
                alusrcb    = SRCB_RS2;
                alucontrol = alu_dec_c;
                state_d    = S_ALUWB;
            end

            S_EXECI: begin
                alusrca    = SRCA_RS1;
                alusrcb    = SRCB_IMM;
                immsrc     = IMM_I;
                alucontrol = alu_dec_c;
                state_d    = S_ALUWB;
            end

            S_ALUWB: begin
                resultsrc  = RES_ALUOUT;
                regwrite_c = 1'b1;
                state_d    = S_FETCH;
            end

            // funct3[0] inverts the condition: beq takes on zero, bne on !zero
            S_BRANCH: begin
                alusrca    = SRCA_RS1;
                alusrcb    = SRCB_RS2;
                alucontrol = ALU_SUB;
                resultsrc  = RES_ALUOUT;
                pcwrite_c  = zero ^ funct3[0];
                state_d    = S_FETCH;
            end

            // Link value OldPC+4 is computed while PC loads the target
            S_JAL: begin
                alusrca    = SRCA_OLDPC;
                alusrcb    = SRCB_FOUR;
                alucontrol = ALU_ADD;
                resultsrc  = RES_ALUOUT;
                immsrc     = IMM_J;
                pcwrite_c  = 1'b1;
                state_d    = S_ALUWB;
            end

`ifdef UTYPE_SUPPORT_EN
            // auipc adds OldPC; lui adds to a forced-zero A operand
            S_UTYPE: begin
                alusrca    = op[5] ? SRCA_ZERO : SRCA_OLDPC;
                alusrcb    = SRCB_IMM;
                immsrc     = IMM_U;
                alucontrol = ALU_ADD;
                state_d    = S_ALUWB;
            end
`endif

            // Absorbing; only reset leaves
            S_TRAP: begin
                state_d = S_TRAP;
            end

            // Unused encodings recover through FETCH
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign pcwrite  = pcwrite_c  & rst_n;
    assign irwrite  = irwrite_c  & rst_n;
    assign memwrite = memwrite_c & rst_n;
    assign regwrite = regwrite_c & rst_n;
    assign illegal  = illegal_q;
    assign state    = state_q;

endmodule
